multisim_qs_push_arbiter: RTL and testbench

- Shares one quasi-static push channel between NUM_CPUS per-CPU data words (e.g. IRQ vectors).
- Detects which CPU's word has changed since it was last sent, picks one with a round-robin arbiter, and presents it with a CPU index on a valid/ready channel.
- Sits in front of the per-CPU multisim server instances, so N CPUs need only one server connection.

---
 rtl/multisim_arb_pkg.sv | 35 +++
 rtl/multisim_qs_push_arbiter_rr.sv | 24 ++
 rtl/multisim_qs_push_arbiter.sv | 101 ++++++++++
 tb/tb_multisim_qs_push_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multisim_arb_pkg.sv
// Shared types and the round-robin search used by the multisim push arbiter.
package multisim_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } arb_state_e;

  localparam int unsigned RR_MAX_N   = 64;
  localparam int unsigned RR_IDX_W   = 6;
  localparam int unsigned CNT_WIDTH  = 32;

  // Returns the first set request scanning ptr, ptr+1, ..., wrapping at n; -1 if none.
  function automatic int rr_search(input logic [RR_MAX_N-1:0] req,
                                   input int unsigned         ptr,
                                   input int unsigned         n);
    int          result;
    int unsigned idx;
    result = -1;
    idx    = 0;
    for (int unsigned off = 0; off < RR_MAX_N; off++) begin
      if (off < n) begin
        idx = ptr + off;
        if (idx >= n) begin
          idx = idx - n;
        end
        if ((result < 0) && req[idx[RR_IDX_W-1:0]]) begin
          result = int'(idx);
        end
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/multisim_qs_push_arbiter_rr.sv
// Combinational round-robin arbiter; the rotating pointer is owned by the parent.
module rr_arbiter
  import multisim_arb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_grant_valid_c,
  output logic [IW-1:0] o_grant_idx_c
);

  logic [RR_MAX_N-1:0] w_req_ext;
  int                  w_result;

  always_comb begin
    w_req_ext       = RR_MAX_N'(i_req);
    w_result        = rr_search(w_req_ext, 32'(i_ptr), N);
    o_grant_valid_c = (w_result >= 0);
    o_grant_idx_c   = (w_result >= 0) ? IW'(w_result) : '0;
  end

endmodule

// File: rtl/multisim_qs_push_arbiter.sv
// Funnels NUM_CPUS quasi-static words onto one valid/ready push channel,
// sending a CPU's word whenever it differs from the last value sent or a flush forces it.
module multisim_qs_push_arbiter
  import multisim_arb_pkg::*;
#(
  parameter int unsigned NUM_CPUS   = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IDX_WIDTH  = $clog2(NUM_CPUS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CPUS*DATA_WIDTH-1:0] i_data,
  input  logic                           i_flush,
  output logic                           o_push_valid,
  output logic [IDX_WIDTH-1:0]           o_push_index,
  output logic [DATA_WIDTH-1:0]          o_push_data,
  input  logic                           i_push_ready,
  output logic [CNT_WIDTH-1:0]           o_xfer_count
);

  arb_state_e            r_state;
  logic [DATA_WIDTH-1:0] r_shadow [NUM_CPUS];
  logic [NUM_CPUS-1:0]   r_force;
  logic [IDX_WIDTH-1:0]  r_ptr;

  logic [DATA_WIDTH-1:0] w_words [NUM_CPUS];
  logic [NUM_CPUS-1:0]   w_req;
  logic                  w_grant_valid;
  logic [IDX_WIDTH-1:0]  w_grant_idx;
  logic [IDX_WIDTH-1:0]  w_ptr_next;

  always_comb begin
    for (int unsigned k = 0; k < NUM_CPUS; k++) begin
      w_words[k] = i_data[k*DATA_WIDTH +: DATA_WIDTH];
      w_req[k]   = r_force[k] | (w_words[k] != r_shadow[k]);
    end
  end

  rr_arbiter #(
    .N  (NUM_CPUS),
    .IW (IDX_WIDTH)
  ) u_rr (
    .i_req           (w_req),
    .i_ptr           (r_ptr),
    .o_grant_valid_c (w_grant_valid),
    .o_grant_idx_c   (w_grant_idx)
  );

  // Pointer moves past the granted CPU, wrapping explicitly for non-power-of-two counts.
  always_comb begin
    w_ptr_next = o_push_index + IDX_WIDTH'(1);
    if (o_push_index == IDX_WIDTH'(NUM_CPUS - 1)) begin
      w_ptr_next = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_force      <= '0;
      r_ptr        <= '0;
      o_push_valid <= 1'b0;
      o_push_index <= '0;
      o_push_data  <= '0;
      o_xfer_count <= '0;
      for (int unsigned k = 0; k < NUM_CPUS; k++) begin
        r_shadow[k] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_valid) begin
            o_push_index <= w_grant_idx;
            o_push_data  <= w_words[w_grant_idx];
            o_push_valid <= 1'b1;
            r_state      <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (i_push_ready) begin
            r_shadow[o_push_index] <= o_push_data;
            r_force[o_push_index]  <= 1'b0;
            r_ptr                  <= w_ptr_next;
            o_xfer_count           <= o_xfer_count + CNT_WIDTH'(1);
            o_push_valid           <= 1'b0;
            r_state                <= ST_IDLE;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          o_push_valid <= 1'b0;
        end
      endcase
      // Last assignment wins, so a flush on a completing edge keeps that CPU forced.
      if (i_flush) begin
        r_force <= '1;
      end
    end
  end

endmodule

// File: tb/tb_multisim_qs_push_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a transaction-level model.
module tb_multisim_qs_push_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] data;
  logic            flush;
  logic            ready;
  logic            push_valid;
  logic [IW-1:0]   push_index;
  logic [DW-1:0]   push_data;
  logic [31:0]     xfer_count;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [DW-1:0] m_shadow [N];
  bit            m_force  [N];
  int            m_ptr;
  bit            m_valid;
  int            m_idx;
  logic [DW-1:0] m_data;
  logic [31:0]   m_cnt;

  multisim_qs_push_arbiter #(
    .NUM_CPUS   (N),
    .DATA_WIDTH (DW),
    .IDX_WIDTH  (IW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_data       (data),
    .i_flush      (flush),
    .o_push_valid (push_valid),
    .o_push_index (push_index),
    .o_push_data  (push_data),
    .i_push_ready (ready),
    .o_xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] word(input int k);
    return data[k*DW +: DW];
  endfunction

  task automatic set_word(input int k, input logic [DW-1:0] v);
    data[k*DW +: DW] = v;
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_shadow[k] = '0;
      m_force[k]  = 0;
    end
    m_ptr   = 0;
    m_valid = 0;
    m_idx   = 0;
    m_data  = '0;
    m_cnt   = '0;
  endtask

  // One transaction-level step using the inputs presented for the coming edge.
  task automatic model_edge();
    int g;
    if (rst) return;
    if (!m_valid) begin
      g = -1;
      for (int o = 0; o < N; o++) begin
        int k;
        k = (m_ptr + o) % N;
        if (g < 0 && (m_force[k] || word(k) != m_shadow[k])) g = k;
      end
      if (g >= 0) begin
        m_valid = 1;
        m_idx   = g;
        m_data  = word(g);
      end
    end else if (ready) begin
      m_shadow[m_idx] = m_data;
      m_force[m_idx]  = 0;
      m_ptr           = (m_idx + 1) % N;
      m_cnt           = m_cnt + 1;
      m_valid         = 0;
    end
    if (flush) begin
      for (int k = 0; k < N; k++) m_force[k] = 1;
    end
  endtask

  task automatic compare_all();
    check("valid", 64'(push_valid), 64'(m_valid));
    if (m_valid) begin
      check("index", 64'(push_index), 64'(m_idx));
      check("data", 64'(push_data), 64'(m_data));
    end
    check("count", 64'(xfer_count), 64'(m_cnt));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic async_reset_pulse();
    rst = 1'b1;
    #1;
    check("rst_drops_valid", 64'(push_valid), 64'd0);
    model_reset();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int grants [$];
    int cnt0;
    bit saw0;
    bit flushed0;

    rst   = 1'b1;
    data  = '0;
    flush = 1'b0;
    ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 64'(push_valid), 64'd0);
    check("reset_index", 64'(push_index), 64'd0);
    check("reset_data", 64'(push_data), 64'd0);
    check("reset_count", 64'(xfer_count), 64'd0);
    rst = 1'b0;

    // quiet after reset with all-zero words
    repeat (20) tick();
    check("idle_count", 64'(xfer_count), 64'd0);

    // single change on CPU2
    ready = 1'b1;
    set_word(2, 32'h0000_0010);
    tick();
    check("t2_valid", 64'(push_valid), 64'd1);
    check("t2_index", 64'(push_index), 64'd2);
    check("t2_data", 64'(push_data), 64'h10);
    tick();
    check("t2_done_valid", 64'(push_valid), 64'd0);
    check("t2_count", 64'(xfer_count), 64'd1);

    // send CPU3 so the pointer returns to 0, then three simultaneous changes
    set_word(3, 32'h33);
    repeat (2) tick();
    set_word(0, 32'h100);
    set_word(1, 32'h101);
    set_word(3, 32'h103);
    grants.delete();
    for (int c = 0; c < 8; c++) begin
      tick();
      if (push_valid) grants.push_back(int'(push_index));
    end
    check("t3_ngrants", 64'(grants.size()), 64'd3);
    if (grants.size() == 3) begin
      check("t3_g0", 64'(grants[0]), 64'd0);
      check("t3_g1", 64'(grants[1]), 64'd1);
      check("t3_g2", 64'(grants[2]), 64'd3);
    end
    check("t3_count", 64'(xfer_count), 64'd5);

    // CPU1 changes while its transfer is stalled
    ready = 1'b0;
    set_word(1, 32'hA);
    tick();
    check("t4_index", 64'(push_index), 64'd1);
    set_word(1, 32'hB);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("t4_hold_data", 64'(push_data), 64'hA);
    end
    ready = 1'b1;
    tick();
    check("t4_done", 64'(push_valid), 64'd0);
    tick();
    check("t4_resend_index", 64'(push_index), 64'd1);
    check("t4_resend_data", 64'(push_data), 64'hB);
    tick();

    // flush with everything already sent: one transfer per CPU
    repeat (2) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (10) tick();
    check("t5_flush_count", 64'(xfer_count), 64'd11);

    // flush landing on CPU0's completing edge yields a second CPU0 transfer
    flush = 1'b1;
    tick();
    flush = 1'b0;
    cnt0 = 0;
    saw0 = 0;
    flushed0 = 0;
    for (int c = 0; c < 24; c++) begin
      if (push_valid && push_index == 0) begin
        cnt0++;
        saw0 = 1;
        if (!flushed0) begin
          flush = 1'b1;
          flushed0 = 1;
        end
      end
      tick();
      flush = 1'b0;
    end
    check("t5_saw_cpu0", 64'(saw0), 64'd1);
    check("t5_cpu0_twice", 64'(cnt0), 64'd2);

    // reset in the middle of a transfer
    ready = 1'b0;
    set_word(2, 32'h55);
    tick();
    check("t6_in_send", 64'(push_valid), 64'd1);
    async_reset_pulse();
    ready = 1'b1;
    tick();
    check("t6_restart_valid", 64'(push_valid), 64'd1);
    check("t6_restart_index", 64'(push_index), 64'd0);
    repeat (10) tick();

    // random traffic with a small value alphabet so words often revert
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0)
        set_word(int'($urandom_range(0, N - 1)), DW'($urandom_range(0, 3)));
      ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 499) == 0) begin
        flush = 1'b0;
        async_reset_pulse();
      end else begin
        tick();
      end
    end
    flush = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
